// File: rtl/and_or_filter_array.sv
// CHANNELS independent AND-OR(-invert) channels, each registered and then debounced
// by a FILTER_CYCLES stability filter. Define AND_OR_FILTER_MASK_EN to add the term_mask port.
module and_or_filter_array #(
  parameter int CHANNELS      = 2,
  parameter int GROUPS        = 2,
  parameter int TERMS         = 3,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               invert,
  input  logic [CHANNELS*GROUPS*TERMS-1:0]   in_bits,
`ifdef AND_OR_FILTER_MASK_EN
  input  logic [CHANNELS*GROUPS*TERMS-1:0]   term_mask,
`endif
  output logic [CHANNELS-1:0]                y,
  output logic [CHANNELS-1:0]                chg
);

  localparam int NBITS = CHANNELS * GROUPS * TERMS;
  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [NBITS-1:0] mask_w;

`ifdef AND_OR_FILTER_MASK_EN
  assign mask_w = term_mask;
`else
  assign mask_w = '0;
`endif

  // A masked term reads as 1; a group whose terms are all masked drops out of the OR.
  function automatic logic channel_or(input logic [NBITS-1:0] bits,
                                      input logic [NBITS-1:0] mask,
                                      input int               c);
    logic any_grp;
    logic prod;
    logic all_m;
    any_grp = 1'b0;
    for (int g = 0; g < GROUPS; g++) begin
      prod  = 1'b1;
      all_m = 1'b1;
      for (int t = 0; t < TERMS; t++) begin
        prod  = prod & (bits[(c*GROUPS+g)*TERMS+t] | mask[(c*GROUPS+g)*TERMS+t]);
        all_m = all_m & mask[(c*GROUPS+g)*TERMS+t];
      end
      any_grp = any_grp | (prod & ~all_m);
    end
    return any_grp;
  endfunction

  logic [CHANNELS-1:0] raw;

  always_comb begin
    raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      raw[c] = channel_or(in_bits, mask_w, c) ^ invert;
    end
  end

  logic [CHANNELS-1:0]            r_raw_q, r_raw_d;
  logic [CHANNELS-1:0]            y_q, y_d;
  logic [CHANNELS-1:0]            chg_q, chg_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every next-state signal gets a hold/default value first so no path leaves it unassigned (no latch).
  always_comb begin
    r_raw_d = r_raw_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    chg_d   = '0;
    if (en) begin
      r_raw_d = raw;
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_raw_q[c] == y_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          y_d[c]   = r_raw_q[c];
          cnt_d[c] = '0;
          chg_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_q <= '0;
      y_q     <= '0;
      chg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      r_raw_q <= r_raw_d;
      y_q     <= y_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y   = y_q;
  assign chg = chg_q;

endmodule

// File: tb/tb_and_or_filter_array.sv
// Directed self-checking bench for and_or_filter_array at default parameters.
// Exercises the term_mask path when AND_OR_FILTER_MASK_EN is defined.
module tb_and_or_filter_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       invert;
  logic [11:0] in_bits;
`ifdef AND_OR_FILTER_MASK_EN
  logic [11:0] term_mask;
`endif
  logic [1:0] y;
  logic [1:0] chg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_or_filter_array #(
    .CHANNELS(2), .GROUPS(2), .TERMS(3), .FILTER_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .invert   (invert),
    .in_bits  (in_bits),
`ifdef AND_OR_FILTER_MASK_EN
    .term_mask(term_mask),
`endif
    .y        (y),
    .chg      (chg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    invert  = 1'b0;
    in_bits = '0;
`ifdef AND_OR_FILTER_MASK_EN
    term_mask = '0;
`endif
    #12;
    checks++;
    if (y !== 2'b00 || chg !== 2'b00) begin
      failures++;
      $display("FAIL reset_hold y=%b chg=%b expected y=00 chg=00", y, chg);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (y !== 2'b00 || chg !== 2'b00) begin
        failures++;
        $display("FAIL reset_release edge=%0d y=%b chg=%b expected y=00 chg=00", i, y, chg);
      end
    end
  endtask

  task automatic test_latency();
    logic [1:0] ey, ec;
    in_bits = 12'b000000_000111;
    for (int i = 1; i <= 7; i++) begin
      tick();
      ey = (i >= 5) ? 2'b01 : 2'b00;
      ec = (i == 5) ? 2'b01 : 2'b00;
      checks++;
      if (y !== ey || chg !== ec) begin
        failures++;
        $display("FAIL latency_rise edge=%0d y=%b chg=%b expected y=%b chg=%b", i, y, chg, ey, ec);
      end
    end
    in_bits = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      ey = (i >= 5) ? 2'b00 : 2'b01;
      ec = (i == 5) ? 2'b01 : 2'b00;
      checks++;
      if (y !== ey || chg !== ec) begin
        failures++;
        $display("FAIL latency_fall edge=%0d y=%b chg=%b expected y=%b chg=%b", i, y, chg, ey, ec);
      end
    end
  endtask

  task automatic test_pulse();
    logic [1:0] ey, ec;
    // 3-cycle pulse on channel 1 group 0 is rejected
    in_bits = 12'b000111_000000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) in_bits = '0;
      checks++;
      if (y !== 2'b00 || chg !== 2'b00) begin
        failures++;
        $display("FAIL pulse3 edge=%0d y=%b chg=%b expected y=00 chg=00", i, y, chg);
      end
    end
    // 4-cycle pulse just reaches the threshold, then the return also filters through
    in_bits = 12'b000111_000000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) in_bits = '0;
      ey = (i >= 5 && i < 9) ? 2'b10 : 2'b00;
      ec = (i == 5 || i == 9) ? 2'b10 : 2'b00;
      checks++;
      if (y !== ey || chg !== ec) begin
        failures++;
        $display("FAIL pulse4 edge=%0d y=%b chg=%b expected y=%b chg=%b", i, y, chg, ey, ec);
      end
    end
  endtask

  task automatic test_invert();
    logic [1:0] ey, ec;
    in_bits = 12'b000000_000111;
    for (int i = 1; i <= 6; i++) tick();
    checks++;
    if (y !== 2'b01) begin
      failures++;
      $display("FAIL invert_setup y=%b expected 01", y);
    end
    invert = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      ey = (i >= 5) ? 2'b10 : 2'b01;
      ec = (i == 5) ? 2'b11 : 2'b00;
      checks++;
      if (y !== ey || chg !== ec) begin
        failures++;
        $display("FAIL invert edge=%0d y=%b chg=%b expected y=%b chg=%b", i, y, chg, ey, ec);
      end
    end
  endtask

  task automatic test_enable();
    logic [1:0] ey, ec;
    // y=10 now; dropping invert flips both channels back toward 01
    invert = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (y !== 2'b10 || chg !== 2'b00) begin
        failures++;
        $display("FAIL enable_frozen edge=%0d y=%b chg=%b expected y=10 chg=00", i, y, chg);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      ey = (i >= 2) ? 2'b01 : 2'b10;
      ec = (i == 2) ? 2'b11 : 2'b00;
      checks++;
      if (y !== ey || chg !== ec) begin
        failures++;
        $display("FAIL enable_resume edge=%0d y=%b chg=%b expected y=%b chg=%b", i, y, chg, ey, ec);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ey, ec;
    invert = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 2'b00 || chg !== 2'b00) begin
      failures++;
      $display("FAIL reset_async y=%b chg=%b expected y=00 chg=00", y, chg);
    end
    // all inputs 0 with invert=1 makes every raw value 1
    in_bits = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      ey = (i >= 5) ? 2'b11 : 2'b00;
      ec = (i == 5) ? 2'b11 : 2'b00;
      checks++;
      if (y !== ey || chg !== ec) begin
        failures++;
        $display("FAIL reset_rise edge=%0d y=%b chg=%b expected y=%b chg=%b", i, y, chg, ey, ec);
      end
    end
  endtask

`ifdef AND_OR_FILTER_MASK_EN
  task automatic test_mask();
    logic [1:0] ey, ec;
    rst_n = 1'b0;
    invert = 1'b0;
    in_bits = '0;
    term_mask = 12'b000000_000111;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (y !== 2'b00 || chg !== 2'b00) begin
        failures++;
        $display("FAIL mask_full edge=%0d y=%b chg=%b expected y=00 chg=00", i, y, chg);
      end
    end
    term_mask = 12'b000000_000001;
    in_bits   = 12'b000000_000110;
    for (int i = 1; i <= 6; i++) begin
      tick();
      ey = (i >= 5) ? 2'b01 : 2'b00;
      ec = (i == 5) ? 2'b01 : 2'b00;
      checks++;
      if (y !== ey || chg !== ec) begin
        failures++;
        $display("FAIL mask_bit0 edge=%0d y=%b chg=%b expected y=%b chg=%b", i, y, chg, ey, ec);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_pulse();
    test_invert();
    test_enable();
    test_reset_mid();
`ifdef AND_OR_FILTER_MASK_EN
    test_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
